// File: rtl/mux2_bus_arbiter.sv
// rtl/mux2_bus_arbiter.sv - two-requester round-robin arbiter driving the shared 2:1 path select
// Optional hold-timeout preemption is enabled by defining ARB_TIMEOUT_EN.
module mux2_bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ0,
  input  logic REQ1,
  input  logic DONE0,
  input  logic DONE1,
  output logic GNT0,
  output logic GNT1,
  output logic SEL,
  output logic BUSY
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

  state_t state;
  state_t state_nxt;
  logic   last;
  logic   last_nxt;
  logic   sel_nxt;
  logic   force_rel;

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;

  // Owner is forced off once it has held the path MAX_HOLD cycles while the other side waits
  always_comb begin
    force_rel = 1'b0;
    if (hold_cnt == HOLD_LIMIT) begin
      force_rel = (state == OWN0) ? REQ1 : REQ0;
    end
  end

  // Hold count restarts on every ownership entry and saturates instead of wrapping
  always_comb begin
    hold_nxt = hold_cnt;
    if ((state_nxt == OWN0 || state_nxt == OWN1) && state_nxt != state) begin
      hold_nxt = '0;
    end else if ((state == OWN0 || state == OWN1) && hold_cnt != HOLD_SAT) begin
      hold_nxt = hold_cnt + 1'b1;
    end
  end

  // Hold counter register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_nxt;
    end
  end
`else
  logic [HOLD_W-1:0] unused_cfg;

  assign unused_cfg = HOLD_W'(MAX_HOLD);
  assign force_rel  = 1'b0;
`endif

  // Next-state, priority pointer and select decisions
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = SEL;
    case (state)
      IDLE: begin
        if (REQ0 && (!REQ1 || last)) begin
          state_nxt = OWN0;
          sel_nxt   = 1'b0;
        end else if (REQ1) begin
          state_nxt = OWN1;
          sel_nxt   = 1'b1;
        end
      end
      OWN0: begin
        if (DONE0 || !REQ0 || force_rel) begin
          last_nxt = 1'b0;
          if (REQ1) begin
            state_nxt = TURN;
            sel_nxt   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      OWN1: begin
        if (DONE1 || !REQ1 || force_rel) begin
          last_nxt = 1'b1;
          if (REQ0) begin
            state_nxt = TURN;
            sel_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      TURN: begin
        // SEL already points at the incoming owner; give up if it withdrew
        if (SEL ? REQ1 : REQ0) begin
          state_nxt = SEL ? OWN1 : OWN0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant immediately
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      last  <= 1'b1;
      GNT0  <= 1'b0;
      GNT1  <= 1'b0;
      SEL   <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      GNT0  <= (state_nxt == OWN0);
      GNT1  <= (state_nxt == OWN1);
      SEL   <= sel_nxt;
      BUSY  <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_mux2_bus_arbiter.sv
// tb/tb_mux2_bus_arbiter.sv - self-checking bench for mux2_bus_arbiter (optional ARB_TIMEOUT_EN build)
module tb_mux2_bus_arbiter;

  typedef struct packed {
    logic g0;
    logic g1;
    logic sel;
    logic busy;
  } out_t;

  typedef struct packed {
    logic r0;
    logic r1;
    logic d0;
    logic d1;
    out_t exp;
  } vec_t;

  logic CLK;
  logic RST;
  logic REQ0;
  logic REQ1;
  logic DONE0;
  logic DONE1;
  logic GNT0;
  logic GNT1;
  logic SEL;
  logic BUSY;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t exp_q[$];
  logic prev_any = 1'b0;
  logic prev_sel = 1'b0;

  mux2_bus_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ0 (REQ0),
    .REQ1 (REQ1),
    .DONE0(DONE0),
    .DONE1(DONE1),
    .GNT0 (GNT0),
    .GNT1 (GNT1),
    .SEL  (SEL),
    .BUSY (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Grant exclusivity and select stability, every cycle
  always @(negedge CLK) begin
    if (RST) begin
      prev_any = 1'b0;
    end else begin
      n_checks++;
      if (GNT0 && GNT1) begin
        n_fail++;
        $display("FAIL grant_exclusive: GNT0=%b GNT1=%b, required not both 1", GNT0, GNT1);
      end
      if (prev_any && (GNT0 || GNT1)) begin
        n_checks++;
        if (SEL !== prev_sel) begin
          n_fail++;
          $display("FAIL sel_stable: SEL=%b, required %b while granted", SEL, prev_sel);
        end
      end
      prev_any = GNT0 || GNT1;
      prev_sel = SEL;
    end
  end

  task automatic check_out(input string name);
    out_t e;
    out_t a;
    e = exp_q.pop_front();
    a = '{g0: GNT0, g1: GNT1, sel: SEL, busy: BUSY};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got gnt0/gnt1/sel/busy=%b, required %b", name, a, e);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic d0, input logic d1,
                       input out_t e, input string name);
    REQ0  = r0;
    REQ1  = r1;
    DONE0 = d0;
    DONE1 = d1;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    check_out(name);
  endtask

  task automatic do_reset();
    REQ0  = 1'b0;
    REQ1  = 1'b0;
    DONE0 = 1'b0;
    DONE1 = 1'b0;
    RST   = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    // r0 r1 d0 d1 | g0 g1 sel busy
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b1, 1'b1}};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, '{1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b1, 1'b1}};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, '{1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, '{1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b1, 1'b1}};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b1, 1'b1}};
    vecs[15] = '{1'b0, 0, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b0}};

    REQ0  = 1'b0;
    REQ1  = 1'b0;
    DONE0 = 1'b0;
    DONE1 = 1'b0;
    RST   = 1'b1;

    // reset state before any clock edge
    #2;
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
    check_out("reset_no_edge");
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // table: single requester, alternation, ignored DONEs, withdrawal in TURN
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // tie from reset goes to requester 0, then strict alternation
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b0, 1'b0, 1'b1}, "alt_own0");
    drive(1'b1, 1'b1, 1'b1, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b1}, "alt_turn1");
    drive(1'b1, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b1, 1'b1}, "alt_own1");
    drive(1'b1, 1'b1, 1'b0, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b1}, "alt_turn0");
    drive(1'b1, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b0, 1'b0, 1'b1}, "alt_own0b");

    // hold limit with a waiting second requester
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '{1'b1, 1'b0, 1'b0, 1'b1}, "hold_enter");
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b0, 1'b0, 1'b1}, $sformatf("hold_own0_%0d", i));
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b1}, "hold_turn");
    drive(1'b1, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b1, 1'b1}, "hold_own1");
`else
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b0, 1'b0, 1'b1}, $sformatf("hold_own0_%0d", i));
    end
`endif

    // non-owner DONE ignored, async reset mid-ownership, pointer restored
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b1, 1'b1}, "rst_own1");
    drive(1'b0, 1'b1, 1'b1, 1'b0, '{1'b0, 1'b1, 1'b1, 1'b1}, "rst_done0_ignored");
    DONE0 = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
    check_out("rst_async_clear");
    #1;
    RST = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b0, 1'b0, 1'b1}, "rst_tie_req0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
